// File: rtl/irq_ctrl6502_pkg.sv
// Shared register offsets, NMI sequencer states and the vector priority helper
// for the 6502 interrupt controller.
package irq_ctrl6502_pkg;

    localparam logic [1:0] IC_STATUS = 2'd0;
    localparam logic [1:0] IC_ENABLE = 2'd1;
    localparam logic [1:0] IC_MODE   = 2'd2;
    localparam logic [1:0] IC_VECTOR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } nmi_state_t;

    // Lowest set bit wins; an empty vector returns 0.
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_edge6502.sv
// Multi-flop synchroniser for one asynchronous input with rising-edge detect.
// The level output is taken one flop later so it lines up with an edge latch.
module sync_edge6502 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign lvl  = prev_r;
    assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/irq_ctrl6502.sv
// Memory-mapped interrupt controller feeding cpu6502 irq/nmi: per-source
// level/edge capture, masking, vector priority and a queued NMI pulse sequencer.
module irq_ctrl6502
    import irq_ctrl6502_pkg::*;
#(
    parameter int          NSRC        = 8,
    parameter logic [15:0] BASE_ADDR   = 16'hDF00,
    parameter int          SYNC_STAGES = 2,
    parameter int          NMI_PULSE   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     address,
    input  logic            write,
    input  logic [7:0]      wr_data,
    output logic [7:0]      rd_data,
    output logic            rd_hit,
    input  logic [NSRC-1:0] src_in,
    input  logic            nmi_in,
    output logic            irq,
    output logic            nmi
);

    localparam int CNT_W = (NMI_PULSE > 1) ? $clog2(NMI_PULSE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NMI_PULSE - 1);

    logic [NSRC-1:0] src_lvl, src_rise;
    logic            nmi_rise;
    logic            nmi_lvl;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        sync_edge6502 #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (src_in[i]),
            .lvl     (src_lvl[i]),
            .rise    (src_rise[i])
        );
    end

    sync_edge6502 #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nmi (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (nmi_in),
        .lvl     (nmi_lvl),
        .rise    (nmi_rise)
    );

    logic       hit, wr_en, rd_en;
    logic [1:0] off;

    assign hit   = (address[15:2] == BASE_ADDR[15:2]);
    assign off   = address[1:0];
    assign wr_en = hit & write;
    assign rd_en = hit & ~write;

    logic [NSRC-1:0] enable_r, mode_r, latch_r;
    logic [NSRC-1:0] pending, clr, drop, latch_n;
    logic [7:0]      pending8, active8, vector8, rd_mux;

    assign pending  = (mode_r & latch_r) | (~mode_r & src_lvl);
    assign pending8 = 8'(pending);
    assign active8  = 8'(pending & enable_r);
    assign vector8  = {|active8, 4'b0000, lowest_index(active8)};

    // Edge set beats a same-cycle W1C; dropping a source to level mode wipes its hidden latch.
    assign clr     = (wr_en && off == IC_STATUS) ? wr_data[NSRC-1:0] : '0;
    assign drop    = (wr_en && off == IC_MODE) ? (mode_r & ~wr_data[NSRC-1:0]) : '0;
    assign latch_n = ((latch_r & ~clr) | (src_rise & mode_r)) & ~drop;

    always_comb begin
        rd_mux = 8'h00;
        unique case (off)
            IC_STATUS: rd_mux = pending8;
            IC_ENABLE: rd_mux = 8'(enable_r);
            IC_MODE:   rd_mux = 8'(mode_r);
            IC_VECTOR: rd_mux = vector8;
            default:   rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_r <= '0;
            mode_r   <= '0;
            latch_r  <= '0;
            irq      <= 1'b0;
            rd_data  <= 8'h00;
            rd_hit   <= 1'b0;
        end else begin
            latch_r <= latch_n;
            irq     <= |active8;
            rd_hit  <= rd_en;
            rd_data <= rd_en ? rd_mux : 8'h00;
            if (wr_en && off == IC_ENABLE) enable_r <= wr_data[NSRC-1:0];
            if (wr_en && off == IC_MODE)   mode_r   <= wr_data[NSRC-1:0];
        end
    end

    nmi_state_t       state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic             queue_r, queue_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            queue_r <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            queue_r <= queue_n;
        end
    end

    // One NMI may wait behind the current pulse; it launches straight out of the gap.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        queue_n = queue_r;
        nmi     = 1'b0;
        unique case (state_r)
            ST_IDLE: begin
                if (nmi_rise) begin
                    state_n = ST_PULSE;
                    cnt_n   = '0;
                end
            end
            ST_PULSE: begin
                nmi = 1'b1;
                if (nmi_rise) queue_n = 1'b1;
                if (cnt_r == CNT_LAST) state_n = ST_GAP;
                else                   cnt_n   = cnt_r + CNT_W'(1);
            end
            ST_GAP: begin
                queue_n = 1'b0;
                cnt_n   = '0;
                state_n = (queue_r || nmi_rise) ? ST_PULSE : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl6502.sv
// Scoreboard bench for irq_ctrl6502: a delay-line reference model predicts
// irq/nmi/rd_hit every cycle and read data per access; directed cases plus random traffic.
module tb_irq_ctrl6502;

    localparam logic [15:0] BASE = 16'hDF00;
    localparam logic [15:0] IDLE_ADDR = 16'h0200;
    localparam int S = 2;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] address;
    logic        write;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic [7:0]  src_in;
    logic        nmi_in;
    logic        irq;
    logic        nmi;

    irq_ctrl6502 #(.NSRC(8), .BASE_ADDR(BASE), .SYNC_STAGES(S), .NMI_PULSE(P)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .address (address),
        .write   (write),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rd_hit  (rd_hit),
        .src_in  (src_in),
        .nmi_in  (nmi_in),
        .irq     (irq),
        .nmi     (nmi)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic irq; logic nmi; logic hit; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] rd_q[$];

    logic [7:0] m_en, m_mode, m_latch;
    logic [7:0] sh[0:S];
    logic       nh[0:S];
    int         step, cur_start;
    bit         queued;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_en = 8'h00; m_mode = 8'h00; m_latch = 8'h00;
            for (int i = 0; i <= S; i++) begin sh[i] = 8'h00; nh[i] = 1'b0; end
            step = 0; cur_start = -1000; queued = 0;
            exp_q.delete();
            rd_q.delete();
        end else begin
            logic [7:0]  lvl, rise, pend, act, vec, clr, drop;
            logic [15:0] diff;
            logic        in_win, nrise;
            int          ph;
            exp_t        e;
            step++;
            // source seen through the synchroniser is the sample from S steps back
            lvl  = sh[S];
            rise = sh[S-1] & ~sh[S];
            pend = (m_mode & m_latch) | (~m_mode & lvl);
            act  = pend & m_en;
            vec  = 8'h00;
            for (int i = 7; i >= 0; i--) if (act[i]) vec = 8'h80 | 8'(i);
            in_win = (address >= BASE) && (address <= BASE + 16'd3);
            diff   = address - BASE;
            e.irq  = |act;
            e.hit  = in_win && !write;
            if (e.hit) begin
                case (diff[1:0])
                    2'd0:    rd_q.push_back(pend);
                    2'd1:    rd_q.push_back(m_en);
                    2'd2:    rd_q.push_back(m_mode);
                    default: rd_q.push_back(vec);
                endcase
            end
            clr = 8'h00; drop = 8'h00;
            if (in_win && write && diff[1:0] == 2'd0) clr = wr_data;
            if (in_win && write && diff[1:0] == 2'd2) drop = m_mode & ~wr_data;
            m_latch = ((m_latch & ~clr) | (rise & m_mode)) & ~drop;
            if (in_win && write && diff[1:0] == 2'd1) m_en = wr_data;
            if (in_win && write && diff[1:0] == 2'd2) m_mode = wr_data;
            // NMI as a timeline: pulse occupies steps cur_start..cur_start+P-1, gap at +P
            nrise = nh[S-1] & ~nh[S];
            ph = step - 1 - cur_start;
            if (ph >= 0 && ph < P) begin
                if (nrise) queued = 1;
            end else if (ph == P) begin
                if (queued || nrise) begin cur_start = step; queued = 0; end
            end else if (nrise) begin
                cur_start = step;
            end
            e.nmi = (step - cur_start >= 0) && (step - cur_start < P);
            for (int i = S; i > 0; i--) begin sh[i] = sh[i-1]; nh[i] = nh[i-1]; end
            sh[0] = src_in;
            nh[0] = nmi_in;
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        exp_t       e;
        logic [7:0] d;
        @(negedge clk);
        if (reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk1("sb_irq", irq, e.irq);
            chk1("sb_nmi", nmi, e.nmi);
            chk1("sb_rd_hit", rd_hit, e.hit);
            if (rd_hit || e.hit) begin
                if (rd_q.size() > 0) begin
                    d = rd_q.pop_front();
                    if (rd_hit) chk8("sb_rd_data", rd_data, d);
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_rd_data: got hit with data %02h, required no read", rd_data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        address = a; write = 1'b1; wr_data = d;
        @(negedge clk);
        address = IDLE_ADDR; write = 1'b0; wr_data = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        address = a; write = 1'b0;
        @(negedge clk);
        chk1({name, "_hit"}, rd_hit, 1'b1);
        chk8(name, rd_data, exp);
        address = IDLE_ADDR;
    endtask

    initial begin
        int pulses, gap, w0, w1, b, sel, waited;
        logic prev;
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pulses, gap, b, sel, waited;
        int  w[2];
        logic prev;
        reset_n = 1'b0; address = IDLE_ADDR; write = 1'b0; wr_data = 8'h00;
        src_in = 8'h00; nmi_in = 1'b0;
        #1;
        chk1("reset_irq", irq, 1'b0);
        chk1("reset_nmi", nmi, 1'b0);
        chk1("reset_rd_hit", rd_hit, 1'b0);
        chk8("reset_rd_data", rd_data, 8'h00);
        @(posedge clk); #2 reset_n = 1'b1;
        @(negedge clk);

        // read timing and window boundary
        rd_chk("rd_mode", BASE + 16'd2, 8'h00);
        address = BASE + 16'd4;
        @(negedge clk);
        chk1("rd_out_of_window", rd_hit, 1'b0);
        address = IDLE_ADDR;

        // level source: 4-cycle latency both ways, W1C ignored
        bus_wr(BASE + 16'd2, 8'h00);
        bus_wr(BASE + 16'd1, 8'h01);
        src_in = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk1("lvl_irq_rise", irq, k == 4);
        end
        bus_wr(BASE, 8'h01);
        chk1("lvl_w1c_ignored", irq, 1'b1);
        src_in = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk1("lvl_irq_fall", irq, k != 4);
        end

        // edge latch and write-1-to-clear
        bus_wr(BASE + 16'd2, 8'hFF);
        bus_wr(BASE + 16'd1, 8'h0C);
        src_in[3] = 1'b1;
        @(negedge clk);
        src_in[3] = 1'b0;
        repeat (5) @(negedge clk);
        rd_chk("edge_status", BASE, 8'h08);
        rd_chk("edge_vector", BASE + 16'd3, 8'h83);
        chk1("edge_irq", irq, 1'b1);
        bus_wr(BASE, 8'h08);
        @(negedge clk);
        chk1("w1c_irq", irq, 1'b0);
        rd_chk("w1c_vector", BASE + 16'd3, 8'h00);

        // new edge on the very cycle of a W1C: set wins
        bus_wr(BASE + 16'd1, 8'h04);
        src_in[2] = 1'b1;
        @(negedge clk);
        src_in[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk1("collide_pre_irq", irq, 1'b1);
        src_in[2] = 1'b1;
        @(negedge clk);
        src_in[2] = 1'b0;
        @(negedge clk);
        bus_wr(BASE, 8'h04);
        rd_chk("collide_status", BASE, 8'h04);
        chk1("collide_irq", irq, 1'b1);
        bus_wr(BASE, 8'hFF);
        bus_wr(BASE + 16'd1, 8'h00);

        // three NMI edges inside one pulse -> two pulses
        pulses = 0; gap = 0; w[0] = 0; w[1] = 0; prev = 1'b0;
        for (int k = 0; k < 30; k++) begin
            nmi_in = (k == 0 || k == 2 || k == 4);
            @(negedge clk);
            if (nmi) begin
                if (!prev) pulses++;
                if (pulses >= 1 && pulses <= 2) w[pulses-1]++;
            end else if (pulses == 1) begin
                gap++;
            end
            prev = nmi;
        end
        chk8("nmi_pulse_count", 8'(pulses), 8'd2);
        chk8("nmi_width0", 8'(w[0]), 8'd4);
        chk8("nmi_width1", 8'(w[1]), 8'd4);
        chk8("nmi_gap", 8'(gap), 8'd1);

        // async reset in the middle of an NMI pulse
        bus_wr(BASE + 16'd2, 8'h00);
        bus_wr(BASE + 16'd1, 8'h01);
        src_in = 8'h01;
        repeat (5) @(negedge clk);
        nmi_in = 1'b1;
        waited = 0;
        while (!nmi && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        nmi_in = 1'b0;
        chk1("nmi_seen_before_reset", nmi, 1'b1);
        address = BASE + 16'd1;
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk1("midreset_nmi", nmi, 1'b0);
        chk1("midreset_irq", irq, 1'b0);
        chk8("midreset_rd_data", rd_data, 8'h00);
        src_in = 8'h00;
        address = IDLE_ADDR;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        rd_chk("enable_after_reset", BASE + 16'd1, 8'h00);

        // random traffic against the model
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 9) < 3) begin
                b = $urandom_range(0, 7);
                src_in[b] = ~src_in[b];
            end
            if ($urandom_range(0, 19) == 0) nmi_in = ~nmi_in;
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2, 3: address = BASE + 16'(sel);
                4:          address = BASE + 16'd4;
                default:    address = BASE - 16'd1;
            endcase
            case ($urandom_range(0, 5))
                0, 1: begin address = IDLE_ADDR; write = 1'b0; end
                2, 3: write = 1'b0;
                default: begin write = 1'b1; wr_data = 8'($urandom); end
            endcase
            @(negedge clk);
        end
        address = IDLE_ADDR; write = 1'b0; src_in = 8'h00; nmi_in = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
